// File: rtl/mul_div_sequencer.sv
// Multi-cycle signed 32x32 multiply (radix-4 Booth) / divide (non-restoring) unit.
// Optional abort input is enabled by defining MULDIV_ABORT_EN.
module mul_div_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        op_mul,
  input  logic        op_div,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MULDIV_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] Chigh,
  output logic [31:0] Clow
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d;
  logic [32:0] mpl_q, mpl_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;
  logic [31:0] chigh_q, chigh_d;
  logic [31:0] clow_q, clow_d;
  logic        dbz_q, dbz_d;

  logic [63:0] pp;
  logic [63:0] acc_sum;
  logic [32:0] rem_sh;
  logic [32:0] rem_step;
  logic [32:0] rem_fix;
  logic        abort_w;

`ifdef MULDIV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign busy        = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign Chigh       = chigh_q;
  assign Clow        = clow_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mpl_d   = mpl_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    chigh_d = chigh_q;
    clow_d  = clow_q;
    dbz_d   = dbz_q;

    // mcand_q is pre-shifted by 2 bits per digit, so pp already carries weight 4^i
    case (mpl_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
    acc_sum = acc_q + pp;

    rem_sh   = {rem_q[31:0], quo_q[31]};
    rem_step = rem_q[32] ? (rem_sh + {1'b0, dvsr_q}) : (rem_sh - {1'b0, dvsr_q});
    rem_fix  = rem_q[32] ? (rem_q + {1'b0, dvsr_q}) : rem_q;

    if (busy && abort_w) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (op_mul ^ op_div)) begin
            mcand_d = {{32{A[31]}}, A};
            mpl_d   = {B, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = A[31] ? -A : A;
            dvsr_d  = B[31] ? -B : B;
            qsign_d = A[31] ^ B[31];
            rsign_d = A[31];
            state_d = op_mul ? MUL : DIV;
          end
        end
        MUL: begin
          acc_d   = acc_sum;
          mcand_d = mcand_q << 2;
          mpl_d   = {2'b00, mpl_q[32:2]};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            chigh_d = acc_sum[63:32];
            clow_d  = acc_sum[31:0];
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
        DIV: begin
          // |B|==0 only when B==0; mcand_q[31:0] still holds the raw dividend
          if (dvsr_q == '0) begin
            chigh_d = mcand_q[31:0];
            clow_d  = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d = rem_step;
            quo_d = {quo_q[30:0], ~rem_step[32]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_d = FIX;
            end
          end
        end
        FIX: begin
          rem_d   = rem_fix;
          chigh_d = rsign_q ? -rem_fix[31:0] : rem_fix[31:0];
          clow_d  = qsign_q ? -quo_q : quo_q;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mpl_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      chigh_q <= '0;
      clow_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mpl_q   <= mpl_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      chigh_q <= chigh_d;
      clow_q  <= clow_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: directed and random MUL/DIV against
// an arithmetic reference model; abort scenario only when MULDIV_ABORT_EN is defined.
module tb_mul_div_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic        op_mul;
  logic        op_div;
  logic [31:0] A;
  logic [31:0] B;
`ifdef MULDIV_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] Chigh;
  logic [31:0] Clow;

  int checks = 0;
  int errors = 0;

  mul_div_sequencer dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op_mul      (op_mul),
    .op_div      (op_div),
    .A           (A),
    .B           (B),
`ifdef MULDIV_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .Chigh       (Chigh),
    .Clow        (Clow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = 1'b0;
    if (is_mul) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      dbz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Issues one op, returns cycles from accept edge to done, busy cycle count,
  // busy/done overlap, and whether a start pulsed during DONE was (wrongly) taken.
  task automatic run_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b, input int poke,
                        output int lat, output int bcyc, output bit ovl, output bit late_busy);
    @(posedge clock);
    @(negedge clock);
    start = 1'b1; op_mul = is_mul; op_div = !is_mul; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0; op_mul = 1'b0; op_div = 1'b0; A = $urandom; B = $urandom;
    lat = -1; bcyc = 0; ovl = 1'b0;
    for (int j = 0; j < 60; j++) begin
      if (busy) bcyc++;
      if (busy && done) ovl = 1'b1;
      if (done) begin
        lat = j;
        break;
      end
      if (j == poke) begin
        start = 1'b1; op_div = 1'b1; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0; op_div = 1'b0;
      end
      @(posedge clock); #1;
    end
    start = 1'b1; op_mul = 1'b1; op_div = 1'b0; A = $urandom; B = $urandom;
    @(posedge clock); #1;
    start = 1'b0; op_mul = 1'b0;
    late_busy = busy | done;
  endtask

  task automatic do_op(input string tag, input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                       input int poke);
    logic [31:0] eh, el;
    logic        ed;
    int          elat, lat, bc;
    bit          ovl, lb;
    ref_op(is_mul, a, b, eh, el, ed);
    elat = is_mul ? 16 : ((b == 32'd0) ? 1 : 33);
    run_op(is_mul, a, b, poke, lat, bc, ovl, lb);
    chk({tag, " Chigh"}, 64'(Chigh), 64'(eh));
    chk({tag, " Clow"}, 64'(Clow), 64'(el));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ed));
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " busy_cycles"}, 64'(bc), 64'(elat));
    chk({tag, " busy_done_overlap"}, 64'(ovl), 64'd0);
    chk({tag, " start_in_done"}, 64'(lb), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rmul;
    int          cnt_done, cnt_busy;

    clear = 1'b0; start = 1'b0; op_mul = 1'b0; op_div = 1'b0; A = '0; B = '0;
`ifdef MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    chk("reset Chigh", 64'(Chigh), 64'd0);
    chk("reset Clow", 64'(Clow), 64'd0);
    @(negedge clock);
    clear = 1'b1;

    do_op("mul 7*-3", 1'b1, 32'd7, 32'hFFFF_FFFD, -1);
    chk("mul 7*-3 const lo", 64'(Clow), 64'hFFFF_FFEB);
    do_op("mul min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, -1);
    chk("mul min*min const hi", 64'(Chigh), 64'h4000_0000);
    do_op("mul ffff*ffff", 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, -1);
    chk("mul ffff*ffff const lo", 64'(Clow), 64'hFFFE_0001);
    do_op("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, -1);
    chk("div -7/2 const lo", 64'(Clow), 64'hFFFF_FFFD);
    do_op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div min/-1 const lo", 64'(Clow), 64'h8000_0000);
    do_op("div 5/0", 1'b0, 32'd5, 32'd0, -1);
    chk("div 5/0 const dbz", 64'(div_by_zero), 64'd1);
    do_op("mul 2*3", 1'b1, 32'd2, 32'd3, -1);
    do_op("mul poked", 1'b1, 32'h1234_5678, 32'hFEDC_BA98, 5);
    do_op("div poked", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFF3, 12);

    for (int i = 0; i < 40; i++) begin
      rmul = (i % 2) == 0;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = $urandom_range(1, 15);
        1: rb = -$urandom_range(1, 15);
        2: rb = rmul ? rb : 32'd0;
        3: ra = 32'h8000_0000;
        4: rb = 32'h8000_0000;
        default: ;
      endcase
      do_op(rmul ? "rand mul" : "rand div", rmul, ra, rb, -1);
    end

    // Both op lines, then neither: must stay idle
    @(negedge clock);
    start = 1'b1; op_mul = 1'b1; op_div = 1'b1; A = 32'd9; B = 32'd9;
    @(posedge clock); #1;
    chk("both ops busy", 64'(busy), 64'd0);
    op_mul = 1'b0; op_div = 1'b0;
    @(posedge clock); #1;
    chk("no op busy", 64'(busy), 64'd0);
    start = 1'b0;
    cnt_done = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (done || busy) cnt_done++;
    end
    chk("invalid op activity", 64'(cnt_done), 64'd0);

    // Reset in the middle of a divide
    do_op("mul pre-reset", 1'b1, 32'd2, 32'd3, -1);
    @(negedge clock);
    start = 1'b1; op_div = 1'b1; A = 32'd1000; B = 32'd7;
    @(posedge clock); #1;
    start = 1'b0; op_div = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("mid-div busy", 64'(busy), 64'd1);
    clear = 1'b0;
    #1;
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset done", 64'(done), 64'd0);
    chk("async reset dbz", 64'(div_by_zero), 64'd0);
    chk("async reset Chigh", 64'(Chigh), 64'd0);
    chk("async reset Clow", 64'(Clow), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    cnt_done = 0; cnt_busy = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    chk("post-reset done", 64'(cnt_done), 64'd0);
    chk("post-reset busy", 64'(cnt_busy), 64'd0);

`ifdef MULDIV_ABORT_EN
    do_op("mul 3*4", 1'b1, 32'd3, 32'd4, -1);
    @(negedge clock);
    start = 1'b1; op_div = 1'b1; A = 32'd100; B = 32'd7;
    @(posedge clock); #1;
    start = 1'b0; op_div = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    cnt_done = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) cnt_done++;
    end
    chk("abort no done", 64'(cnt_done), 64'd0);
    chk("abort Clow kept", 64'(Clow), 64'd12);
    chk("abort Chigh kept", 64'(Chigh), 64'd0);
    do_op("div 100/7", 1'b0, 32'd100, 32'd7, -1);
    chk("div 100/7 const lo", 64'(Clow), 64'd14);
    chk("div 100/7 const hi", 64'(Chigh), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
